btn_debounce: RTL and testbench

Debounces one mechanical push-button for the game input path, using the 50 Hz divided clock as its sampling time base. It sits directly downstream of the 40 MHz→50 Hz clock divider and consumes that divider's output as a plain data signal. That signal is synchronised and edge-detected into a one-cycle sample enable; it is never used as a clock. Outputs are a clean level plus one-cycle press/release pulses for the game control FSM, all in the 40 MHz domain.

---
 rtl/btn_pkg.sv | 6 +
 rtl/sync_rise_det.sv | 26 ++
 rtl/btn_debounce.sv | 110 +++++++++++
 tb/tb_btn_debounce.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default parameters for the push-button debouncer.
package btn_pkg;
   typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
   localparam int DEF_STABLE_TICKS = 3;
   localparam int DEF_SYNC_STAGES  = 2;
endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchroniser for an asynchronous level, plus a one-clk rising-edge pulse.
module sync_rise_det #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic d_sync,
   output logic rise
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_async};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign d_sync = sync_q[STAGES-1];
   assign rise   = d_sync & ~prev_q;
endmodule

// File: rtl/btn_debounce.sv
// Button debouncer sampled on rising edges of the divided 50 Hz signal (used as data, not a clock).
module btn_debounce
   import btn_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic clk_slow,
   input  logic btn_in,
   output logic btn_db,
   output logic btn_pressed,
   output logic btn_released
);
   localparam int            CW   = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic          tick;
   logic          slow_s;
   logic          btn_s;
   logic          btn_rise_unused;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;
   logic          pressed_q, pressed_d;
   logic          released_q, released_d;

   sync_rise_det #(.STAGES(SYNC_STAGES)) u_slow_sync (
      .clk(clk), .rst(rst), .d_async(clk_slow), .d_sync(slow_s), .rise(tick)
   );

   sync_rise_det #(.STAGES(SYNC_STAGES)) u_btn_sync (
      .clk(clk), .rst(rst), .d_async(btn_in), .d_sync(btn_s), .rise(btn_rise_unused)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE_LOW;
         cnt_q      <= '0;
         db_q       <= 1'b0;
         pressed_q  <= 1'b0;
         released_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         db_q       <= db_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
      end
   end

   // Any sample opposite to the pending level drops back to the idle state it came from.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pressed_d  = 1'b0;
      released_d = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE_LOW: begin
               if (btn_s) begin
                  state_d = WAIT_HIGH;
                  cnt_d   = ONE;
               end
            end
            WAIT_HIGH: begin
               if (!btn_s) begin
                  state_d = IDLE_LOW;
                  cnt_d   = '0;
               end else if (cnt_q == LAST) begin
                  state_d   = IDLE_HIGH;
                  cnt_d     = '0;
                  pressed_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            IDLE_HIGH: begin
               if (!btn_s) begin
                  state_d = WAIT_LOW;
                  cnt_d   = ONE;
               end
            end
            WAIT_LOW: begin
               if (btn_s) begin
                  state_d = IDLE_HIGH;
                  cnt_d   = '0;
               end else if (cnt_q == LAST) begin
                  state_d    = IDLE_LOW;
                  cnt_d      = '0;
                  released_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            default: begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end
         endcase
      end
      db_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
   end

   assign btn_db       = db_q;
   assign btn_pressed  = pressed_q;
   assign btn_released = released_q;
endmodule

// File: tb/tb_btn_debounce.sv
// Randomised and directed bench for btn_debounce against a run-length model of the debounce rule.
module tb_btn_debounce;
   localparam int ST   = 3;
   localparam int SS   = 2;
   localparam int HALF = 10;

   logic clk = 1'b0;
   logic rst, clk_slow, btn_in;
   logic btn_db, btn_pressed, btn_released;

   int checks = 0;
   int errors = 0;
   int m_level, m_run, exp_p, exp_r;

   always #5 clk = ~clk;

   btn_debounce #(.STABLE_TICKS(ST), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .clk_slow(clk_slow), .btn_in(btn_in),
      .btn_db(btn_db), .btn_pressed(btn_pressed), .btn_released(btn_released)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Level flips after ST consecutive samples that disagree with it.
   task automatic model_sample(input int b);
      exp_p = 0;
      exp_r = 0;
      if (b != m_level) begin
         m_run++;
         if (m_run == ST) begin
            m_level = b;
            m_run   = 0;
            if (b != 0) exp_p = 1;
            else        exp_r = 1;
         end
      end else begin
         m_run = 0;
      end
   endtask

   // One slow period: low phase (optional 3-clk glitch), then rising edge and observation window.
   task automatic slow_period(input logic b, input int glitch, input string tag);
      int np, nr, ip, ir, both, lowp, prev_db, db_before, db_after;
      np = 0; nr = 0; ip = 0; ir = 0; both = 0; lowp = 0;
      db_before = 0; db_after = 0;
      prev_db   = m_level;
      btn_in    = b;
      clk_slow  = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
         @(negedge clk);
         if (btn_pressed || btn_released) lowp++;
         if (glitch != 0 && k == 3) btn_in = ~b;
         if (glitch != 0 && k == 6) btn_in = b;
      end
      @(posedge clk);
      #1 clk_slow = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
         @(negedge clk);
         if (btn_pressed)  begin np++; ip = k; end
         if (btn_released) begin nr++; ir = k; end
         if (btn_pressed && btn_released) both++;
         if (k == SS + 1) db_before = btn_db;
         if (k == SS + 2) db_after  = btn_db;
      end
      model_sample(b);
      chk({tag, " low-phase pulses"}, lowp, 0);
      chk({tag, " pressed count"}, np, exp_p);
      chk({tag, " released count"}, nr, exp_r);
      if (exp_p != 0) chk({tag, " pressed cycle"}, ip, SS + 2);
      if (exp_r != 0) chk({tag, " released cycle"}, ir, SS + 2);
      chk({tag, " both pulses"}, both, 0);
      chk({tag, " db before pulse slot"}, db_before, prev_db);
      chk({tag, " db at pulse slot"}, db_after, m_level);
   endtask

   task automatic mid_reset(input string tag);
      clk_slow = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk({tag, " db"}, btn_db, 0);
      chk({tag, " pressed"}, btn_pressed, 0);
      chk({tag, " released"}, btn_released, 0);
      chk({tag, " cnt"}, int'(dut.cnt_q), 0);
      m_level = 0;
      m_run   = 0;
      repeat (3) begin
         @(negedge clk);
         chk({tag, " held pulses"}, int'(btn_pressed) + int'(btn_released), 0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic bounce [6];
      logic b;
      int   stuck;
      bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      rst = 1'b1; clk_slow = 1'b0; btn_in = 1'b0;
      m_level = 0; m_run = 0; exp_p = 0; exp_r = 0;

      repeat (5) @(posedge clk);
      #1;
      chk("reset db", btn_db, 0);
      chk("reset pressed", btn_pressed, 0);
      chk("reset released", btn_released, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      repeat (20) slow_period(1'b0, 0, "idle");
      repeat (ST) slow_period(1'b1, 0, "press");
      repeat (ST) slow_period(1'b0, 0, "release");
      foreach (bounce[i]) slow_period(bounce[i], 0, "bounce");

      repeat (2) slow_period(1'b1, 1, "glitch high-level");
      repeat (ST) slow_period(1'b0, 0, "release2");
      repeat (2) slow_period(1'b0, 1, "glitch low-level");

      // Slow clock stopped while a press is pending.
      repeat (ST - 1) slow_period(1'b1, 0, "pre-stop");
      clk_slow = 1'b0;
      stuck = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         btn_in = 1'($urandom_range(0, 1));
         if (btn_pressed || btn_released || (int'(btn_db) != m_level)) stuck++;
      end
      chk("stopped slow clock activity", stuck, 0);
      slow_period(1'b1, 0, "resume");

      repeat (ST) slow_period(1'b0, 0, "release3");
      repeat (ST - 1) slow_period(1'b1, 0, "wait-high");
      mid_reset("rst wait-high");
      repeat (ST) slow_period(1'b1, 0, "post-reset press");

      repeat (ST - 1) slow_period(1'b0, 0, "wait-low");
      mid_reset("rst wait-low");
      repeat (2) slow_period(1'b0, 0, "post-reset idle");

      b = 1'b0;
      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 3) == 0) b = ~b;
         slow_period(b, int'($urandom_range(0, 1)), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
